// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory fetch port shared by fetch_queue and the memory side
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC, credit-limited fetch issue, response FIFO
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    fetch_queue_if.master        imem,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 stall,
    output logic                 valid,
    output logic [31:0]          instr,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4
);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   buf_instr_q [DEPTH];
    logic [31:0]   buf_instr_d [DEPTH];
    logic [31:0]   buf_pc_q [DEPTH];
    logic [31:0]   buf_pc_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   ipc_q [DEPTH];
    logic [31:0]   ipc_d [DEPTH];
    logic [PW-1:0] ird_q, ird_d, iwr_q, iwr_d;

    logic rv_eff;
    logic pop;
    logic push;
    logic grant;
    logic dropping;
    logic credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode; responses with nothing outstanding are stale and ignored
    always_comb begin
        valid          = (cnt_q != '0);
        rv_eff         = imem.imem_rvalid && (out_q != '0);
        pop            = valid && !stall && !redirect;
        credit         = (({1'b0, out_q} + {1'b0, cnt_q}) - {{CW{1'b0}}, pop}) < DEPTH_W;
        imem.imem_req  = rstn && credit && !redirect;
        imem.imem_addr = fetch_pc_q;
        grant          = imem.imem_req && imem.imem_gnt;
        dropping       = rv_eff && (drop_q != '0);
        push           = rv_eff && !dropping && !redirect;
    end

    // Decode-facing outputs come straight from the FIFO head registers
    always_comb begin
        instr    = valid ? buf_instr_q[rd_q] : NOP;
        pc       = valid ? buf_pc_q[rd_q] : 32'h0;
        pc_plus4 = valid ? (buf_pc_q[rd_q] + 32'd4) : 32'h0;
    end

    // Next-state: redirect wins and turns every in-flight response into a drop
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        ipc_d       = ipc_q;
        ird_d       = ird_q;
        iwr_d       = iwr_q;
        out_d       = (out_q + CW'(grant)) - CW'(rv_eff);
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_d     = out_q - CW'(rv_eff);
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            ird_d      = '0;
            iwr_d      = '0;
        end else begin
            if (grant) begin
                fetch_pc_d   = fetch_pc_q + 32'd4;
                ipc_d[iwr_q] = fetch_pc_q;
                iwr_d        = ptr_inc(iwr_q);
            end
            if (dropping) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                buf_instr_d[wr_q] = imem.imem_rdata;
                buf_pc_d[wr_q]    = ipc_q[ird_q];
                wr_d              = ptr_inc(wr_q);
                ird_d             = ptr_inc(ird_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            cnt_d = (cnt_q + CW'(push)) - CW'(pop);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            ird_q      <= '0;
            iwr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_instr_q[i] <= NOP;
                buf_pc_q[i]    <= 32'h0;
                ipc_q[i]       <= 32'h0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ird_q       <= ird_d;
            iwr_q       <= iwr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            ipc_q       <= ipc_d;
        end
    end

    // Credit accounting must never let a response land in a full FIFO
    assert property (@(posedge clk) disable iff (!rstn)
        !(push && (cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue against a queue-level model
module tb_fetch_queue;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        valid;
    logic [31:0] instr, pc, pc_plus4;

    fetch_queue_if bus ();

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem        (bus.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .valid       (valid),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;

    // memory side
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    resp_t pend[$];
    int    last_due = 0;
    int    gnt_pct = 100;
    int    lat_min = 1;
    int    lat_max = 1;

    // reference model
    logic [31:0] m_pc;
    int          m_out;
    int          m_drop;
    logic [31:0] m_bpc[$];
    logic [31:0] m_binstr[$];
    logic [31:0] m_ipc[$];

    // per-cycle DUT samples
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_ppc4, s_instr;

    function automatic logic [31:0] memfunc(input logic [31:0] a);
        return 32'h0010_0093 ^ {a[24:0], 7'b0};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_out  = 0;
        m_drop = 0;
        m_bpc.delete();
        m_binstr.delete();
        m_ipc.delete();
    endtask

    task automatic cycle();
        logic        c_gnt, c_rv, e_valid, e_pop, e_req, c_grant, rv_eff;
        logic [31:0] c_rdata, p;
        @(negedge clk);
        c_gnt = ($urandom_range(99) < gnt_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            c_rv    = 1'b1;
            c_rdata = pend[0].data;
        end else begin
            c_rv    = 1'b0;
            c_rdata = $urandom;
        end
        bus.imem_gnt    = c_gnt;
        bus.imem_rvalid = c_rv;
        bus.imem_rdata  = c_rdata;
        #1;
        if (!rstn) model_reset();
        e_valid = (m_bpc.size() > 0);
        e_pop   = e_valid && !stall && !redirect;
        e_req   = rstn && !redirect && ((m_out + m_bpc.size() - int'(e_pop)) < DEPTH);
        check32("valid", {31'b0, valid}, {31'b0, e_valid});
        check32("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
        if (e_req) check32("imem_addr", bus.imem_addr, m_pc);
        if (e_valid) begin
            check32("pc", pc, m_bpc[0]);
            check32("pc_plus4", pc_plus4, m_bpc[0] + 32'd4);
            check32("instr", instr, m_binstr[0]);
        end else begin
            check32("pc_idle", pc, 32'h0);
            check32("pc_plus4_idle", pc_plus4, 32'h0);
            check32("instr_idle", instr, NOP);
        end
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = valid;
        s_pc    = pc;
        s_ppc4  = pc_plus4;
        s_instr = instr;
        @(posedge clk);
        #1;
        if (c_rv) void'(pend.pop_front());
        if (rstn && s_req && c_gnt) begin
            resp_t r;
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            r.data = memfunc(s_addr);
            pend.push_back(r);
        end
        if (rstn) begin
            c_grant = e_req && c_gnt;
            rv_eff  = c_rv && (m_out > 0);
            if (redirect) begin
                m_drop = m_out - int'(rv_eff);
                m_out  = m_out - int'(rv_eff);
                m_bpc.delete();
                m_binstr.delete();
                m_ipc.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (e_pop) begin
                    void'(m_bpc.pop_front());
                    void'(m_binstr.pop_front());
                end
                if (rv_eff) begin
                    m_out--;
                    if (m_drop > 0) m_drop--;
                    else begin
                        p = m_ipc.pop_front();
                        m_bpc.push_back(p);
                        m_binstr.push_back(c_rdata);
                    end
                end
                if (c_grant) begin
                    m_ipc.push_back(m_pc);
                    m_out++;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int lmin, input int lmax);
        rstn     = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        gnt_pct  = 100;
        lat_min  = lmin;
        lat_max  = lmax;
        cycle();
        cycle();
        pend.delete();
        rstn = 1'b1;
    endtask

    task automatic run_until_valid(input string name, input int limit);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!s_valid && k < limit);
        ntotal++;
        if (s_valid) npass++;
        else $display("FAIL %s: valid not seen within %0d cycles", name, limit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int grants;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        model_reset();

        // 1: streaming at one instruction per cycle
        do_reset(1, 1);
        cycle();
        check32("t1_first_req", {31'b0, s_req}, 32'd1);
        check32("t1_first_addr", s_addr, 32'h0);
        cycle();
        check32("t1_not_yet_valid", {31'b0, s_valid}, 32'd0);
        cycle();
        check32("t1_valid", {31'b0, s_valid}, 32'd1);
        check32("t1_pc0", s_pc, 32'h0);
        check32("t1_ppc4_0", s_ppc4, 32'h4);
        check32("t1_instr0", s_instr, 32'h0010_0093);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check32("t1_pc_seq", s_pc, 32'(4 * i));
        end

        // 2: stall from reset release
        do_reset(1, 1);
        stall  = 1'b1;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_req && bus.imem_gnt) grants++;
        end
        check32("t2_grants_le2", {31'b0, grants <= 2}, 32'd1);
        check32("t2_req_off", {31'b0, s_req}, 32'd0);
        check32("t2_frozen_valid", {31'b0, s_valid}, 32'd1);
        check32("t2_frozen_pc", s_pc, 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check32("t2_release_pc", s_pc, 32'(4 * i));
        end

        // 3: redirect with two late responses outstanding
        do_reset(3, 3);
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        run_until_valid("t3_wait", 20);
        check32("t3_pc", s_pc, 32'h100);
        check32("t3_ppc4", s_ppc4, 32'h104);

        // 4: redirect with a coincident response while stalled
        do_reset(2, 2);
        stall = 1'b1;
        cycle();
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2002;
        cycle();
        check32("t4_rvalid_coincident", {31'b0, bus.imem_rvalid}, 32'd1);
        redirect = 1'b0;
        cycle();
        check32("t4_valid_cleared", {31'b0, s_valid}, 32'd0);
        check32("t4_req", {31'b0, s_req}, 32'd1);
        check32("t4_addr", s_addr, 32'h2000);
        stall = 1'b0;
        run_until_valid("t4_wait", 20);
        check32("t4_pc", s_pc, 32'h2000);

        // 4b: redirect while the FIFO is full and stalled
        do_reset(1, 1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        cycle();
        redirect = 1'b0;
        cycle();
        check32("t4b_valid_cleared", {31'b0, s_valid}, 32'd0);
        check32("t4b_addr", s_addr, 32'h3000);
        stall = 1'b0;

        // 5: reset mid-flight, stray responses afterwards
        do_reset(3, 3);
        cycle();
        cycle();
        rstn = 1'b0;
        cycle();
        rstn    = 1'b1;
        gnt_pct = 0;
        for (int i = 0; i < 10 && pend.size() > 0; i++) cycle();
        check32("t5_strays_drained", 32'(pend.size()), 32'd0);
        pend.delete();
        gnt_pct = 100;
        run_until_valid("t5_wait", 20);
        check32("t5_pc", s_pc, RESET_PC);

        // 6: PC wrap at the top of the address space
        do_reset(1, 1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        check32("t6_addr_top", s_addr, 32'hFFFF_FFFC);
        cycle();
        check32("t6_addr_wrap", s_addr, 32'h0);
        run_until_valid("t6_wait", 20);
        check32("t6_pc", s_pc, 32'hFFFF_FFFC);
        check32("t6_ppc4", s_ppc4, 32'h0);

        // randomized traffic
        do_reset(1, 4);
        gnt_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(99) < 30);
            redirect    = ($urandom_range(99) < 4);
            redirect_pc = $urandom;
            cycle();
        end
        redirect = 1'b0;
        stall    = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
